crossroad_phase_scheduler: RTL
==============================

# crossroad_phase_scheduler

Autonomous sequencer for `car_crossroad`. It generates the pulses the crossroad currently takes from the bench:
- `crossroad_status_changed_in`, which advances the light phase.
- `signal_car_to_cross_if_green_in`, which releases one car from each green lane.

Decisions are driven by a slow enable tick and by the four lane car counters. It sits between `clock_seg_display`-style tick generation and `car_crossroad`, and mirrors the crossroad phase internally. Both blocks reset to A-green and the phase advances exactly once per change pulse, so they stay in lockstep.

## Interface
Parameters:
- CNT_W, 4, width of each lane car counter input
- TIMER_W, 8, width of the phase timer
- MIN_GREEN, 4, minimum green duration in ticks (1 ≤ MIN_GREEN ≤ MAX_GREEN < 2^TIMER_W)
- MAX_GREEN, 16, green duration after which a waiting opposite direction forces a change
- YELLOW_TICKS, 2, yellow duration in ticks (≥ 1)
- CROSS_TICKS, 1, ticks between car-release pulses during green (≥ 1)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- tick_in  in  1  one-cycle scheduling enable; all decisions happen on cycles where it is high
- enable_in  in  1  when low, ticks are ignored and all state is frozen
- car_counter_a1, car_counter_a2, car_counter_b1, car_counter_b2  in  CNT_W each  lane occupancy from `car_crossroad`
- crossroad_status_changed_out  out  1  one-cycle pulse that advances the crossroad phase
- signal_car_to_cross_if_green_out  out  1  one-cycle pulse that releases a car from green lanes
- phase_out  out  2  mirrored phase: 0 A_GREEN, 1 A_YELLOW, 2 B_GREEN, 3 B_YELLOW
- phase_timer_out  out  TIMER_W  ticks elapsed in the current phase

## Operation
Derived signals:
- own_busy: the OR-reduce of the lanes of the green direction (a1|a2 in A_GREEN, b1|b2 in B_GREEN).
- opp_busy: the same for the other direction.

State machine A_GREEN → A_YELLOW → B_GREEN → B_YELLOW → A_GREEN. On every tick with enable_in high, nt = phase_timer + 1 (saturating at 2^TIMER_W−1), evaluated per state:

GREEN states exit when opp_busy and either:
- nt ≥ MAX_GREEN, or
- nt ≥ MIN_GREEN and not own_busy.

If opp_busy is low, green holds indefinitely and the timer saturates.

YELLOW states exit when nt ≥ YELLOW_TICKS; no other condition applies.

On an exit:
- Phase advances.
- phase_timer := 0.
- cross_cnt := 0.
- A change pulse is issued.

On a tick without an exit, phase_timer := nt.

Car release (GREEN only, tick, no exit on that tick):
- If own_busy and cross_cnt + 1 ≥ CROSS_TICKS: issue a release pulse and set cross_cnt := 0.
- If own_busy otherwise: cross_cnt += 1.
- If not own_busy: cross_cnt := 0 and no pulse.

No release pulses are issued in YELLOW.

Simultaneous events:
- An exit and a release on the same tick: the exit wins and the release is suppressed. The two outputs are never high together.

enable_in low:
- The FSM, phase_timer and cross_cnt hold their values.
- Both pulse outputs are 0 from the next cycle.

## Timing
- Reset values (the cycle after rst is sampled high): phase_out = 0 (A_GREEN), phase_timer_out = 0, cross_cnt = 0, both pulse outputs = 0.
- Reset mid-operation takes effect on the next edge regardless of tick_in and enable_in. Any pulse that was pending is dropped.
- Registered outputs, 1-cycle latency: a decision made on a tick cycle N produces the pulse high in cycle N+1 only. phase_out and phase_timer_out update at the same edge.
- Pulse width is exactly one clk cycle. At most one pulse is issued per tick.
- Counter inputs are sampled on the tick cycle. Because the crossroad updates a counter one cycle after a release pulse, the next decision sees the post-release counts as long as ticks are ≥ 2 cycles apart, which is required of the tick source.
- A tick_in held high for consecutive cycles is treated as consecutive ticks.

## Test plan
- Reset, tick every 10 cycles, all lanes 0 → phase_out stays 0, no pulses, phase_timer_out saturates at 255.
- a1 = 2, others 0, CROSS_TICKS = 1:
  - A release pulse follows each tick, one cycle later.
  - The bench decrements a1 on each pulse.
  - After the second pulse, no further pulses occur and the phase stays A_GREEN.
- b1 = 3, A lanes empty → change pulse on tick 4 (MIN_GREEN), giving A_YELLOW. Then:
  - Change pulse 2 ticks later (B_GREEN).
  - Release pulses on the next ticks.
- a1 = 15 held constant, b2 = 1 → releases on ticks 1 to 15. On tick 16 there is a change pulse and no release pulse; phase_out becomes 1.
- enable_in low for 5 ticks during A_YELLOW with timer 1 → phase_timer_out stays 1 and no pulses occur. The first tick after re-enable produces a change pulse to B_GREEN.
- rst asserted for one cycle in B_GREEN with timer 7 → the next cycle shows phase_out 0, timer 0, pulses 0.

Source files
------------

// File: rtl/crossroad_phase_scheduler.sv
// rtl/crossroad_phase_scheduler.sv - tick-driven phase and car-release sequencer for car_crossroad
module crossroad_phase_scheduler #(
    parameter int CNT_W        = 4,
    parameter int TIMER_W      = 8,
    parameter int MIN_GREEN    = 4,
    parameter int MAX_GREEN    = 16,
    parameter int YELLOW_TICKS = 2,
    parameter int CROSS_TICKS  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_in,
    input  logic               enable_in,
    input  logic [CNT_W-1:0]   car_counter_a1,
    input  logic [CNT_W-1:0]   car_counter_a2,
    input  logic [CNT_W-1:0]   car_counter_b1,
    input  logic [CNT_W-1:0]   car_counter_b2,
    output logic               crossroad_status_changed_out,
    output logic               signal_car_to_cross_if_green_out,
    output logic [1:0]         phase_out,
    output logic [TIMER_W-1:0] phase_timer_out
);

    typedef enum logic [1:0] {
        A_GREEN  = 2'd0,
        A_YELLOW = 2'd1,
        B_GREEN  = 2'd2,
        B_YELLOW = 2'd3
    } phase_t;

    // cross_cnt never exceeds CROSS_TICKS-1, so clog2(CROSS_TICKS) bits suffice
    localparam int CROSS_W = (CROSS_TICKS > 1) ? $clog2(CROSS_TICKS) : 1;

    localparam logic [TIMER_W-1:0] MIN_T   = TIMER_W'(MIN_GREEN);
    localparam logic [TIMER_W-1:0] MAX_T   = TIMER_W'(MAX_GREEN);
    localparam logic [TIMER_W-1:0] YEL_T   = TIMER_W'(YELLOW_TICKS);
    localparam logic [CROSS_W:0]   CROSS_T = (CROSS_W+1)'(CROSS_TICKS);

    phase_t             phase;
    logic [TIMER_W-1:0] phase_timer;
    logic [CROSS_W-1:0] cross_cnt;
    logic               change_pulse;
    logic               release_pulse;

    logic               a_busy;
    logic               b_busy;
    logic               own_busy;
    logic               opp_busy;
    logic               is_green;
    logic [TIMER_W-1:0] nt;
    logic               do_exit;
    logic [CROSS_W:0]   cross_next;
    logic               release_due;

    always_comb begin
        a_busy      = |{car_counter_a1, car_counter_a2};
        b_busy      = |{car_counter_b1, car_counter_b2};
        // phase[1] selects the B direction for both its green and yellow phases
        own_busy    = phase[1] ? b_busy : a_busy;
        opp_busy    = phase[1] ? a_busy : b_busy;
        is_green    = (phase == A_GREEN) || (phase == B_GREEN);
        nt          = (&phase_timer) ? phase_timer : phase_timer + 1'b1;
        if (is_green)
            do_exit = opp_busy && ((nt >= MAX_T) || ((nt >= MIN_T) && !own_busy));
        else
            do_exit = (nt >= YEL_T);
        cross_next  = {1'b0, cross_cnt} + 1'b1;
        release_due = (cross_next >= CROSS_T);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase         <= A_GREEN;
            phase_timer   <= '0;
            cross_cnt     <= '0;
            change_pulse  <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            change_pulse  <= 1'b0;
            release_pulse <= 1'b0;
            if (tick_in && enable_in) begin
                if (do_exit) begin
                    // an exit takes priority, so a release due on this tick is dropped
                    phase        <= phase_t'(phase + 2'd1);
                    phase_timer  <= '0;
                    cross_cnt    <= '0;
                    change_pulse <= 1'b1;
                end else begin
                    phase_timer <= nt;
                    if (is_green) begin
                        if (!own_busy) begin
                            cross_cnt <= '0;
                        end else if (release_due) begin
                            release_pulse <= 1'b1;
                            cross_cnt     <= '0;
                        end else begin
                            cross_cnt <= cross_cnt + 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign crossroad_status_changed_out     = change_pulse;
    assign signal_car_to_cross_if_green_out = release_pulse;
    assign phase_out                        = phase;
    assign phase_timer_out                  = phase_timer;

endmodule
